fetch_sequencer: RTL and testbench

Control-bus initiator for the program counter. It drives the PC control signals (INC_PC, LOAD_REG, LOAD_SELECT) and the PC load address, and it fetches instructions from instruction memory at the current PC address. It hands each fetched instruction to the decoder with a valid/accept handshake, then advances the PC by increment or branch load. It sits between the program counter, instruction memory and the decode/execute stage.

---
 rtl/fetch_sequencer.sv | 151 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: clears the PC, fetches instructions at PC_ADDR and hands them
// to the decoder, then advances the PC by increment or branch load.
module fetch_sequencer #(
  parameter int               ADDR_W    = 19,
  parameter int               INSTR_W   = 19,
  parameter int               SEL_W     = 3,
  parameter logic [SEL_W-1:0] LOAD_PC   = 3'd0,
  parameter logic [SEL_W-1:0] LOAD_NONE = 3'd7,
  parameter int               TIMEOUT   = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [ADDR_W-1:0]  PC_ADDR,
  output logic [ADDR_W-1:0]  PC_LOAD_ADDR,
  output logic               INC_PC,
  output logic               LOAD_REG,
  output logic [SEL_W-1:0]   LOAD_SELECT,
  output logic               MEM_REQ,
  output logic [ADDR_W-1:0]  MEM_ADDR,
  input  logic               MEM_READY,
  input  logic [INSTR_W-1:0] MEM_RDATA,
  output logic [INSTR_W-1:0] INSTR,
  output logic               INSTR_VALID,
  input  logic               INSTR_ACCEPT,
  input  logic               BRANCH_TAKEN,
  input  logic [ADDR_W-1:0]  BRANCH_TARGET,
  input  logic               HALT,
  output logic               HALTED,
  output logic               FETCH_ERR
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_REQ   = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   wait_cnt_r;
  logic [ADDR_W-1:0]  load_addr_r;
  logic [INSTR_W-1:0] instr_r;
  logic               instr_valid_r;
  logic               halted_r;
  logic               fetch_err_r;

  logic               inc_pc_s;
  logic               load_reg_s;
  logic [SEL_W-1:0]   load_select_s;
  logic [ADDR_W-1:0]  load_addr_s;
  logic               mem_req_s;

  // PC command decode; a reset in the same cycle suppresses any PC update
  always_comb begin
    inc_pc_s      = 1'b0;
    load_reg_s    = 1'b0;
    load_select_s = LOAD_NONE;
    load_addr_s   = load_addr_r;
    if (RESET) begin
      load_select_s = LOAD_NONE;
    end else begin
      case (state_r)
        S_CLEAR: load_select_s = LOAD_PC;
        S_ISSUE: begin
          if (INSTR_ACCEPT && !HALT) begin
            load_select_s = LOAD_PC;
            if (BRANCH_TAKEN) begin
              load_reg_s  = 1'b1;
              load_addr_s = BRANCH_TARGET;
            end else begin
              inc_pc_s = 1'b1;
            end
          end else begin
            load_select_s = LOAD_NONE;
          end
        end
        default: load_select_s = LOAD_NONE;
      endcase
    end
  end

  // Memory request follows the state directly so a zero-wait reply lands this cycle
  always_comb begin
    mem_req_s = (state_r == S_REQ) && !RESET;
  end

  assign INC_PC       = inc_pc_s;
  assign LOAD_REG     = load_reg_s;
  assign LOAD_SELECT  = load_select_s;
  assign PC_LOAD_ADDR = load_addr_s;
  assign MEM_REQ      = mem_req_s;
  assign MEM_ADDR     = mem_req_s ? PC_ADDR : {ADDR_W{1'b0}};
  assign INSTR        = instr_r;
  assign INSTR_VALID  = instr_valid_r;
  assign HALTED       = halted_r;
  assign FETCH_ERR    = fetch_err_r;

  // Sequencer state machine and registered decoder/status outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r       <= S_CLEAR;
      wait_cnt_r    <= {CNT_W{1'b0}};
      load_addr_r   <= {ADDR_W{1'b0}};
      instr_r       <= {INSTR_W{1'b0}};
      instr_valid_r <= 1'b0;
      halted_r      <= 1'b0;
      fetch_err_r   <= 1'b0;
    end else begin
      case (state_r)
        S_CLEAR: state_r <= S_REQ;
        S_REQ: begin
          // A reply on the final wait cycle still counts as a good fetch
          if (MEM_READY) begin
            instr_r       <= MEM_RDATA;
            instr_valid_r <= 1'b1;
            wait_cnt_r    <= {CNT_W{1'b0}};
            state_r       <= S_ISSUE;
          end else if (wait_cnt_r == CNT_TOP) begin
            fetch_err_r <= 1'b1;
            halted_r    <= 1'b1;
            wait_cnt_r  <= {CNT_W{1'b0}};
            state_r     <= S_HALT;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_ONE;
          end
        end
        S_ISSUE: begin
          if (INSTR_ACCEPT) begin
            instr_valid_r <= 1'b0;
            if (HALT) begin
              halted_r <= 1'b1;
              state_r  <= S_HALT;
            end else begin
              if (BRANCH_TAKEN) begin
                load_addr_r <= BRANCH_TARGET;
              end
              state_r <= S_REQ;
            end
          end
        end
        S_HALT: state_r <= S_HALT;
        default: state_r <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural PC and a delay-programmable
// instruction memory that returns address ^ 0x5A5A5.
module tb_fetch_sequencer;

  localparam logic [18:0] KEY = 19'h5A5A5;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [18:0] PC_ADDR;
  logic [18:0] PC_LOAD_ADDR;
  logic        INC_PC;
  logic        LOAD_REG;
  logic [2:0]  LOAD_SELECT;
  logic        MEM_REQ;
  logic [18:0] MEM_ADDR;
  logic        MEM_READY;
  logic [18:0] MEM_RDATA;
  logic [18:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_ACCEPT;
  logic        BRANCH_TAKEN;
  logic [18:0] BRANCH_TARGET;
  logic        HALT;
  logic        HALTED;
  logic        FETCH_ERR;

  int          checks = 0;
  int          errors = 0;
  logic [18:0] pc = 19'h12345;
  int          req_cnt = 0;
  int          mem_delay = 0;
  logic        mem_force = 1'b0;

  fetch_sequencer dut (
    .CLK(CLK), .RESET(RESET), .PC_ADDR(PC_ADDR), .PC_LOAD_ADDR(PC_LOAD_ADDR),
    .INC_PC(INC_PC), .LOAD_REG(LOAD_REG), .LOAD_SELECT(LOAD_SELECT),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_READY(MEM_READY),
    .MEM_RDATA(MEM_RDATA), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_ACCEPT(INSTR_ACCEPT), .BRANCH_TAKEN(BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET), .HALT(HALT), .HALTED(HALTED), .FETCH_ERR(FETCH_ERR)
  );

  always #5 CLK = ~CLK;

  // Behavioural program counter obeying the control encoding
  always @(posedge CLK) begin
    if (LOAD_SELECT == 3'd0) begin
      if (LOAD_REG) pc <= PC_LOAD_ADDR;
      else if (INC_PC) pc <= pc + 19'd1;
      else pc <= 19'd0;
    end
  end
  assign PC_ADDR = pc;

  // Memory replies after mem_delay waiting cycles of a request
  always @(posedge CLK) begin
    if (MEM_REQ && !MEM_READY) req_cnt <= req_cnt + 1;
    else req_cnt <= 0;
  end
  assign MEM_READY = mem_force || (MEM_REQ && (req_cnt == mem_delay));
  assign MEM_RDATA = MEM_ADDR ^ KEY;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_cmd(input string tag, input logic [2:0] sel, input logic inc, input logic ld);
    check({tag, "_sel"}, {29'd0, LOAD_SELECT}, {29'd0, sel});
    check({tag, "_inc"}, {31'd0, INC_PC}, {31'd0, inc});
    check({tag, "_ld"}, {31'd0, LOAD_REG}, {31'd0, ld});
  endtask

  task automatic chk_reset(input string tag);
    chk_cmd(tag, 3'd7, 1'b0, 1'b0);
    check({tag, "_pcla"}, {13'd0, PC_LOAD_ADDR}, 32'd0);
    check({tag, "_req"}, {31'd0, MEM_REQ}, 32'd0);
    check({tag, "_addr"}, {13'd0, MEM_ADDR}, 32'd0);
    check({tag, "_instr"}, {13'd0, INSTR}, 32'd0);
    check({tag, "_valid"}, {31'd0, INSTR_VALID}, 32'd0);
    check({tag, "_halted"}, {31'd0, HALTED}, 32'd0);
    check({tag, "_err"}, {31'd0, FETCH_ERR}, 32'd0);
  endtask

  initial begin
    RESET = 1'b1; INSTR_ACCEPT = 1'b0; BRANCH_TAKEN = 1'b0; HALT = 1'b0;
    BRANCH_TARGET = 19'd0;
    step(); step();
    chk_reset("rst");

    // 1: zero-wait memory, accept tied high
    RESET = 1'b0; INSTR_ACCEPT = 1'b1; mem_delay = 0; #1;
    chk_cmd("t1_clear", 3'd0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("t1_req", {31'd0, MEM_REQ}, 32'd1);
      check("t1_addr", {13'd0, MEM_ADDR}, i);
      chk_cmd("t1_hold", 3'd7, 1'b0, 1'b0);
      step();
      check("t1_instr", {13'd0, INSTR}, {13'd0, 19'(i) ^ KEY});
      check("t1_valid", {31'd0, INSTR_VALID}, 32'd1);
      chk_cmd("t1_inc", 3'd0, 1'b1, 1'b0);
      step();
    end

    // 2: memory waits 5 cycles, decoder accepts on the 3rd valid cycle
    INSTR_ACCEPT = 1'b0; mem_delay = 4; #1;
    for (int k = 0; k < 5; k++) begin
      check("t2_req", {31'd0, MEM_REQ}, 32'd1);
      check("t2_addr", {13'd0, MEM_ADDR}, 32'd4);
      check("t2_sel", {29'd0, LOAD_SELECT}, 32'd7);
      step();
    end
    for (int j = 0; j < 2; j++) begin
      check("t2_valid", {31'd0, INSTR_VALID}, 32'd1);
      check("t2_req_lo", {31'd0, MEM_REQ}, 32'd0);
      check("t2_sel", {29'd0, LOAD_SELECT}, 32'd7);
      step();
    end
    check("t2_instr", {13'd0, INSTR}, {13'd0, 19'd4 ^ KEY});

    // 3: branch at PC=4
    INSTR_ACCEPT = 1'b1; BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 19'h7FFF0; #1;
    chk_cmd("t3_load", 3'd0, 1'b0, 1'b1);
    check("t3_pcla", {13'd0, PC_LOAD_ADDR}, 32'h7FFF0);
    step();
    INSTR_ACCEPT = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 19'h00123; mem_delay = 0; #1;
    check("t3_addr", {13'd0, MEM_ADDR}, 32'h7FFF0);
    check("t3_valid", {31'd0, INSTR_VALID}, 32'd0);
    check("t3_pcla_hold", {13'd0, PC_LOAD_ADDR}, 32'h7FFF0);
    step();
    check("t3_instr", {13'd0, INSTR}, {13'd0, 19'h7FFF0 ^ KEY});

    // 4: HALT beats BRANCH_TAKEN; late MEM_READY pulses are ignored
    INSTR_ACCEPT = 1'b1; HALT = 1'b1; BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 19'h11111; #1;
    chk_cmd("t4_hold", 3'd7, 1'b0, 1'b0);
    step();
    mem_force = 1'b1;
    check("t4_halted", {31'd0, HALTED}, 32'd1);
    check("t4_valid", {31'd0, INSTR_VALID}, 32'd0);
    check("t4_err", {31'd0, FETCH_ERR}, 32'd0);
    for (int k = 0; k < 22; k++) begin
      check("t4_req", {31'd0, MEM_REQ}, 32'd0);
      check("t4_sel", {29'd0, LOAD_SELECT}, 32'd7);
      check("t4_stay", {31'd0, HALTED}, 32'd1);
      step();
    end
    check("t4_nofetch", {31'd0, INSTR_VALID}, 32'd0);
    mem_force = 1'b0; INSTR_ACCEPT = 1'b0; HALT = 1'b0; BRANCH_TAKEN = 1'b0;
    RESET = 1'b1;
    step();
    chk_reset("t4_rst");
    RESET = 1'b0; mem_delay = 1000; #1;
    chk_cmd("t4_clear", 3'd0, 1'b0, 1'b0);
    step();

    // 5a: memory never answers
    for (int k = 0; k < 16; k++) begin
      check("t5_req", {31'd0, MEM_REQ}, 32'd1);
      check("t5_err_lo", {31'd0, FETCH_ERR}, 32'd0);
      step();
    end
    check("t5_err", {31'd0, FETCH_ERR}, 32'd1);
    check("t5_halted", {31'd0, HALTED}, 32'd1);
    check("t5_req_lo", {31'd0, MEM_REQ}, 32'd0);
    step(); step();
    check("t5_sticky", {31'd0, FETCH_ERR}, 32'd1);

    // 5b: reply on the 16th cycle is a normal fetch
    RESET = 1'b1;
    step();
    RESET = 1'b0; mem_delay = 15;
    step();
    for (int k = 0; k < 16; k++) begin
      check("t5b_req", {31'd0, MEM_REQ}, 32'd1);
      step();
    end
    check("t5b_valid", {31'd0, INSTR_VALID}, 32'd1);
    check("t5b_err", {31'd0, FETCH_ERR}, 32'd0);
    check("t5b_halted", {31'd0, HALTED}, 32'd0);
    check("t5b_instr", {13'd0, INSTR}, {13'd0, KEY});

    // 6b: reset during an accepted handshake in S_ISSUE
    INSTR_ACCEPT = 1'b1; RESET = 1'b1; #1;
    chk_cmd("t6b_cmd", 3'd7, 1'b0, 1'b0);
    step();
    chk_reset("t6b_rst");
    check("t6b_pc", {13'd0, pc}, 32'd0);
    INSTR_ACCEPT = 1'b0; RESET = 1'b0; mem_delay = 0;
    step();

    // 6a: reset during S_REQ while memory answers
    check("t6a_pre", {31'd0, MEM_REQ}, 32'd1);
    RESET = 1'b1; mem_force = 1'b1; #1;
    check("t6a_req", {31'd0, MEM_REQ}, 32'd0);
    chk_cmd("t6a_cmd", 3'd7, 1'b0, 1'b0);
    step();
    chk_reset("t6a_rst");
    mem_force = 1'b0; RESET = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
